uart_rx_fifo: RTL and testbench

Receive-side buffer between `uart_core` and the APB register block. It captures each word that `uart_core` reports with `rx_done_o`, together with its parity-error flag, and acknowledges it through `host_read_data_i`. It then presents the words to the register block in first-word-fall-through order. While the FIFO is full it withholds the acknowledge, so `uart_core` keeps `rts_n` deasserted and hardware flow control throttles the remote transmitter. No word is ever dropped.

---
 rtl/uart_rx_fifo_if.sv | 36 +++
 rtl/uart_rx_fifo.sv | 145 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between uart_core, the RX FIFO and the APB register block.
// The master side drives captures/pops/controls; the FIFO is the slave.
interface uart_rx_fifo_if #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 32
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              rx_done_i;
   logic [DATA_W-1:0] rx_data_i;
   logic              parity_error_i;
   logic              host_read_data_o;
   logic              rd_en_i;
   logic [DATA_W-1:0] rd_data_o;
   logic              rd_parity_error_o;
   logic              empty_o;
   logic              full_o;
   logic              almost_full_o;
   logic [CNT_W-1:0]  count_o;
   logic              stall_o;
   logic              underflow_o;
   logic              flush_i;
   logic              clear_flags_i;

   modport master (
      output rx_done_i, rx_data_i, parity_error_i, rd_en_i, flush_i, clear_flags_i,
      input  host_read_data_o, rd_data_o, rd_parity_error_o, empty_o, full_o,
             almost_full_o, count_o, stall_o, underflow_o
   );

   modport slave (
      input  rx_done_i, rx_data_i, parity_error_i, rd_en_i, flush_i, clear_flags_i,
      output host_read_data_o, rd_data_o, rd_parity_error_o, empty_o, full_o,
             almost_full_o, count_o, stall_o, underflow_o
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive buffer between uart_core and the register block: captures words on rx_done,
// acknowledges them, and withholds the acknowledge while full so flow control throttles.
module uart_rx_fifo #(
   parameter int DEPTH    = 8,
   parameter int DATA_W   = 32,
   parameter int AF_LEVEL = 6
) (
   input logic           clk,
   input logic           reset,
   uart_rx_fifo_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic {
      IDLE,
      WAIT_LOW
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [DATA_W:0]   mem [DEPTH];
   logic [DATA_W:0]   head;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              ack;
   logic              stall;
   logic              underflow;
   logic              is_full;
   logic              is_empty;
   logic              do_write;
   logic              do_pop;
   logic              stall_set;
   logic              underflow_set;

   assign is_full  = (count == CNT_W'(DEPTH));
   assign is_empty = (count == '0);

   // Capture decisions; a flush suppresses the write and freezes the FSM so a
   // pending word is taken on a later cycle instead of being lost.
   always_comb begin
      state_next    = state;
      do_write      = 1'b0;
      stall_set     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.rx_done_i) begin
               if (is_full) begin
                  stall_set = 1'b1;
               end else if (!bus.flush_i) begin
                  do_write   = 1'b1;
                  state_next = WAIT_LOW;
               end
            end
         end
         WAIT_LOW: begin
            if (!bus.rx_done_i && !bus.flush_i) begin
               state_next = IDLE;
            end
         end
      endcase
      do_pop        = bus.rd_en_i && !is_empty && !bus.flush_i;
      underflow_set = bus.rd_en_i && is_empty;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (bus.flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_write, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately left out of reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr] <= {bus.parity_error_i, bus.rx_data_i};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ack <= 1'b0;
      end else begin
         ack <= do_write;
      end
   end

   // Sticky flags: a new set event outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall     <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (stall_set) begin
            stall <= 1'b1;
         end else if (bus.clear_flags_i) begin
            stall <= 1'b0;
         end
         if (underflow_set) begin
            underflow <= 1'b1;
         end else if (bus.clear_flags_i) begin
            underflow <= 1'b0;
         end
      end
   end

   assign head                  = mem[rd_ptr];
   assign bus.rd_data_o         = is_empty ? '0 : head[DATA_W-1:0];
   assign bus.rd_parity_error_o = is_empty ? 1'b0 : head[DATA_W];
   assign bus.host_read_data_o  = ack;
   assign bus.empty_o           = is_empty;
   assign bus.full_o            = is_full;
   assign bus.almost_full_o     = (count >= CNT_W'(AF_LEVEL));
   assign bus.count_o           = count;
   assign bus.stall_o           = stall;
   assign bus.underflow_o       = underflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: capture/ack, backpressure, wrap, underflow,
// flush and mid-transfer reset, with hand-computed expectations.
module tb_uart_rx_fifo;

   localparam int DEPTH    = 8;
   localparam int DATA_W   = 32;
   localparam int AF_LEVEL = 6;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

   uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AF_LEVEL(AF_LEVEL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive inputs, let one rising edge sample them, then settle 1 time unit.
   task automatic applyStimulus(input logic done, input logic [DATA_W-1:0] data,
                                input logic par, input logic rd, input logic fl,
                                input logic clr);
      bus.rx_done_i      = done;
      bus.rx_data_i      = data;
      bus.parity_error_i = par;
      bus.rd_en_i        = rd;
      bus.flush_i        = fl;
      bus.clear_flags_i  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_ack"},   64'(bus.host_read_data_o),  64'd0);
      checkOutput({tag, "_empty"}, 64'(bus.empty_o),           64'd1);
      checkOutput({tag, "_full"},  64'(bus.full_o),            64'd0);
      checkOutput({tag, "_af"},    64'(bus.almost_full_o),     64'd0);
      checkOutput({tag, "_count"}, 64'(bus.count_o),           64'd0);
      checkOutput({tag, "_stall"}, 64'(bus.stall_o),           64'd0);
      checkOutput({tag, "_uflow"}, 64'(bus.underflow_o),       64'd0);
      checkOutput({tag, "_data"},  64'(bus.rd_data_o),         64'd0);
      checkOutput({tag, "_par"},   64'(bus.rd_parity_error_o), 64'd0);
   endtask

   task automatic captureWord(input logic [DATA_W-1:0] data, input logic par);
      applyStimulus(1'b1, data, par, 1'b0, 1'b0, 1'b0);
      checkOutput("cap_ack", 64'(bus.host_read_data_o), 64'd1);
      applyStimulus(1'b0, data, par, 1'b0, 1'b0, 1'b0);
      checkOutput("cap_ack_drop", 64'(bus.host_read_data_o), 64'd0);
   endtask

   task automatic popWord(input logic [DATA_W-1:0] exp_data, input logic exp_par);
      checkOutput("pop_data", 64'(bus.rd_data_o), 64'(exp_data));
      checkOutput("pop_par",  64'(bus.rd_parity_error_o), 64'(exp_par));
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      logic [DATA_W-1:0] q[$];
      int                acks;
      vectors     = 0;
      miscompares = 0;

      reset = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      checkReset("rst");

      // Single capture and read
      applyStimulus(1'b1, 32'h0000_00A5, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t1_ack",   64'(bus.host_read_data_o), 64'd1);
      checkOutput("t1_count", 64'(bus.count_o), 64'd1);
      checkOutput("t1_empty", 64'(bus.empty_o), 64'd0);
      checkOutput("t1_data",  64'(bus.rd_data_o), 64'h0A5);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t1_ack_drop", 64'(bus.host_read_data_o), 64'd0);
      checkOutput("t1_count2",   64'(bus.count_o), 64'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("t1_empty2", 64'(bus.empty_o), 64'd1);
      checkOutput("t1_data2",  64'(bus.rd_data_o), 64'd0);
      checkOutput("t1_count3", 64'(bus.count_o), 64'd0);

      // Fill to full, then backpressure on a ninth word
      for (int i = 1; i <= 8; i++) begin
         captureWord(32'(i), (i == 3));
         checkOutput("fill_count", 64'(bus.count_o), 64'(i));
         checkOutput("fill_af",    64'(bus.almost_full_o), 64'(i >= 6));
         checkOutput("fill_full",  64'(bus.full_o), 64'(i == 8));
         checkOutput("fill_head",  64'(bus.rd_data_o), 64'd1);
      end
      applyStimulus(1'b1, 32'h9, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_ack",   64'(bus.host_read_data_o), 64'd0);
      checkOutput("bp_stall", 64'(bus.stall_o), 64'd1);
      checkOutput("bp_count", 64'(bus.count_o), 64'd8);
      applyStimulus(1'b1, 32'h9, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_ack_held", 64'(bus.host_read_data_o), 64'd0);
      applyStimulus(1'b1, 32'h9, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("bp_pop_ack",   64'(bus.host_read_data_o), 64'd0);
      checkOutput("bp_pop_count", 64'(bus.count_o), 64'd7);
      checkOutput("bp_pop_head",  64'(bus.rd_data_o), 64'd2);
      applyStimulus(1'b1, 32'h9, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_late_ack",  64'(bus.host_read_data_o), 64'd1);
      checkOutput("bp_late_full", 64'(bus.full_o), 64'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_ack_drop", 64'(bus.host_read_data_o), 64'd0);
      for (int i = 2; i <= 9; i++) begin
         popWord(32'(i), (i == 3));
      end
      checkOutput("bp_drained", 64'(bus.empty_o), 64'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("bp_stall_clr", 64'(bus.stall_o), 64'd0);

      // Simultaneous push and pop at count 3
      captureWord(32'h11, 1'b0);
      captureWord(32'h12, 1'b0);
      captureWord(32'h13, 1'b0);
      applyStimulus(1'b1, 32'h14, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("pp_ack",   64'(bus.host_read_data_o), 64'd1);
      checkOutput("pp_count", 64'(bus.count_o), 64'd3);
      checkOutput("pp_head",  64'(bus.rd_data_o), 64'h12);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("pp_count2", 64'(bus.count_o), 64'd3);
      popWord(32'h12, 1'b0);
      popWord(32'h13, 1'b0);
      popWord(32'h14, 1'b0);

      // Twenty words streamed through the eight-entry ring
      for (int k = 0; k < 20; k++) begin
         captureWord(32'h100 + 32'(k), 1'b0);
         q.push_back(32'h100 + 32'(k));
         if (q.size() >= 4) popWord(q.pop_front(), 1'b0);
         checkOutput("wrap_count", 64'(bus.count_o), 64'(q.size()));
      end
      while (q.size() > 0) popWord(q.pop_front(), 1'b0);
      checkOutput("wrap_empty", 64'(bus.empty_o), 64'd1);

      // Done flag held high for ten cycles
      acks = 0;
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
         if (bus.host_read_data_o) acks++;
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("hold_acks",  64'(acks), 64'd1);
      checkOutput("hold_count", 64'(bus.count_o), 64'd1);
      popWord(32'h55, 1'b0);

      // Underflow and flag clearing
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("uf_set",   64'(bus.underflow_o), 64'd1);
      checkOutput("uf_count", 64'(bus.count_o), 64'd0);
      checkOutput("uf_empty", 64'(bus.empty_o), 64'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("uf_clr", 64'(bus.underflow_o), 64'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("uf_set_wins", 64'(bus.underflow_o), 64'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("uf_clr2", 64'(bus.underflow_o), 64'd0);
      captureWord(32'h77, 1'b0);
      checkOutput("uf_after_count", 64'(bus.count_o), 64'd1);
      popWord(32'h77, 1'b0);

      // Flush coinciding with a capture at count 5
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) captureWord(32'h21 + 32'(i), (i == 2));
      checkOutput("fl_pre_count", 64'(bus.count_o), 64'd5);
      applyStimulus(1'b1, 32'h26, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("fl_count", 64'(bus.count_o), 64'd0);
      checkOutput("fl_ack",   64'(bus.host_read_data_o), 64'd0);
      checkOutput("fl_empty", 64'(bus.empty_o), 64'd1);
      applyStimulus(1'b1, 32'h26, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("fl_cap_ack",   64'(bus.host_read_data_o), 64'd1);
      checkOutput("fl_cap_count", 64'(bus.count_o), 64'd1);
      checkOutput("fl_cap_data",  64'(bus.rd_data_o), 64'h26);
      checkOutput("fl_cap_par",   64'(bus.rd_parity_error_o), 64'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset while waiting for the done flag to drop
      applyStimulus(1'b1, 32'h27, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("mr_ack",   64'(bus.host_read_data_o), 64'd1);
      checkOutput("mr_count", 64'(bus.count_o), 64'd2);
      checkOutput("mr_uflow", 64'(bus.underflow_o), 64'd1);
      reset = 1'b1;
      applyStimulus(1'b1, 32'h27, 1'b0, 1'b0, 1'b0, 1'b0);
      checkReset("mr_rst");
      reset = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("mr_post_empty", 64'(bus.empty_o), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
